// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: shift modes and controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves acc by k (0..STEP) positions per op.
// Built as a binary mux chain on the bits of k.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [KW-1:0]    k,
    input  shOp_e            op,
    input  logic             sign,
    output logic [WIDTH-1:0] res
);

    function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] v, input int amt,
                                                 input shOp_e mode, input logic fill);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        r    = v;
        case (mode)
            SH_SLL:  r = v << amt;
            SH_SRL:  r = v >> amt;
            // SRA fills from the sign latched at acceptance, not the running MSB
            SH_SRA:  r = (v >> amt) | (fill ? ~(ones >> amt) : '0);
            SH_ROR:  r = (v >> amt) | (v << (WIDTH - amt));
            default: r = v;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] stages [KW+1];

    assign stages[0] = acc;

    for (genvar s = 0; s < KW; s++) begin : gStage
        assign stages[s+1] = k[s] ? shiftBy(stages[s], 1 << s, op, sign) : stages[s];
    end

    assign res = stages[KW];

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle variable shifter: advances up to STEP bits per clock with
// valid/ready handshakes on request and result sides.
module iter_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int SW    = $clog2(WIDTH),
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [SW:0] STEP_EXT = (SW + 1)'(STEP);

    state_e           state, nextState;
    logic [WIDTH-1:0] acc, outData, stepped;
    logic [SW-1:0]    rem, remNext, kSw;
    logic [KW-1:0]    k;
    shOp_e            op;
    logic             sign;

    // kSw never exceeds rem, so it always fits in SW bits
    assign kSw     = ({1'b0, rem} <= STEP_EXT) ? rem : SW'(STEP);
    assign k       = KW'(kSw);
    assign remNext = rem - kSw;

    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) uStep (
        .acc  (acc),
        .k    (k),
        .op   (op),
        .sign (sign),
        .res  (stepped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = (in_shamt == '0) ? DONE : BUSY;
            BUSY:    if (remNext == '0) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // outData is only written on entry to DONE so it holds through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            rem     <= '0;
            op      <= SH_SLL;
            sign    <= 1'b0;
            outData <= '0;
        end else if (state == IDLE && in_valid) begin
            acc  <= in_data;
            rem  <= in_shamt;
            op   <= shOp_e'(in_op);
            sign <= in_data[WIDTH-1];
            if (in_shamt == '0) outData <= in_data;
        end else if (state == BUSY) begin
            acc <= stepped;
            rem <= remNext;
            if (remNext == '0) outData <= stepped;
        end
    end

    assign out_data = outData;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed table, hand-written corner
// sequences and randomized requests against an arithmetic reference model.
module tb_iter_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [31:0] in_data = '0, out_data;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;

    logic       v8 = 1'b0, r8, ov8, or8 = 1'b1, b8;
    logic [7:0] d8 = '0, od8;
    logic [2:0] s8 = '0;
    logic [1:0] op8 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    iter_shifter #(.WIDTH(8), .STEP(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .in_data(d8), .in_shamt(s8), .in_op(op8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(b8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole shift in one go from the mode definitions.
    function automatic logic [31:0] refShift(input logic [1:0] op, input logic [31:0] d,
                                             input int s, input int w);
        logic [31:0] mask, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        d    = d & mask;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = (d[w-1] && s > 0) ? ((d >> s) | (mask & ~(mask >> s))) : (d >> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (w - s)));
        endcase
        return r & mask;
    endfunction

    task automatic startReq(input logic [1:0] op, input logic [31:0] d, input int s);
        @(negedge clk);
        check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = 5'(s);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called #1 after E0; returns edges after E0 until out_valid is seen.
    task automatic waitValid(output int n, output int lowCnt);
        n = 0; lowCnt = 0;
        while (!out_valid && n < 60) begin
            if (!in_ready) lowCnt++;
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) lowCnt++;
        check("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic runReq(input string name, input logic [1:0] op, input logic [31:0] d,
                          input int s, input logic [31:0] exp);
        int n, lowCnt, expN;
        expN = (s + 3) / 4;
        startReq(op, d, s);
        waitValid(n, lowCnt);
        check({name, "_data"}, out_data, exp);
        check({name, "_lat"}, n, expN);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        lowCnt += in_ready ? 0 : 1;
        check({name, "_ready_low"}, lowCnt, expN + 1);
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic runReq8(input string name, input logic [1:0] op, input logic [7:0] d,
                           input int s, input logic [7:0] exp);
        int n;
        @(negedge clk);
        v8 = 1'b1; op8 = op; d8 = d; s8 = 3'(s);
        @(posedge clk);
        #1 v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_data"}, {24'd0, od8}, {24'd0, exp});
        check({name, "_lat"}, n, s);
        @(posedge clk); #1;
        check({name, "_idle"}, {31'd0, r8}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        vecs[0] = '{2'b00, 32'd70,         2,  32'd280};
        vecs[1] = '{2'b10, 32'h8000_0000, 31,  32'hFFFF_FFFF};
        vecs[2] = '{2'b01, 32'h8000_0000, 31,  32'h0000_0001};
        vecs[3] = '{2'b11, 32'h0000_0001,  1,  32'h8000_0000};
        vecs[4] = '{2'b11, 32'hDEAD_BEEF, 16,  32'hBEEF_DEAD};
        vecs[5] = '{2'b10, 32'h7000_0001,  5,  32'h0380_0000};
        vecs[6] = '{2'b11, 32'h1234_5678,  0,  32'h1234_5678};

        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst8_out_data", {24'd0, od8}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) runReq($sformatf("vec%0d", i), vecs[i].op, vecs[i].data,
                                 vecs[i].shamt, vecs[i].exp);

        // Shift 0 with stalled consumer and ignored requests
        begin
            int n, lowCnt;
            out_ready = 1'b0;
            startReq(2'b00, 32'h1234_5678, 0);
            waitValid(n, lowCnt);
            check("hold_lat", n, 0);
            check("hold_data0", out_data, 32'h1234_5678);
            held = out_data;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                in_valid = c[0]; in_data = 32'hA5A5_0000 + c; in_shamt = 5'd3;
                @(posedge clk); #1;
                check("hold_data", out_data, held);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("hold_release_idle", {31'd0, in_ready}, 32'd1);
            check("hold_out_data_kept", out_data, held);
        end

        // Reset in the middle of a long shift
        startReq(2'b01, 32'hFFFF_FFFF, 20);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        runReq("post_rst", 2'b00, 32'd1, 5, 32'h0000_0020);

        runReq8("w8_sra", 2'b10, 8'h90, 3, 8'hF2);
        runReq8("w8_ror", 2'b11, 8'h81, 7, 8'h03);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] op;
            logic [31:0] d;
            int s;
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = $urandom_range(0, 31);
            runReq($sformatf("rnd%0d_op%0d_s%0d", t, op, s), op, d, s, refShift(op, d, s, 32));
        end
        for (int t = 0; t < 12; t++) begin
            logic [1:0] op;
            logic [7:0] d;
            int s;
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            s  = $urandom_range(0, 7);
            runReq8($sformatf("rnd8_%0d", t), op, d, s, 8'(refShift(op, {24'd0, d}, s, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
